// File: rtl/ex_pkg.sv
// Shared types for the execute stage: opcodes, FSM states and
// default operand/register-index widths.
package ex_pkg;

    localparam int N_DEF  = 32;
    localparam int RW_DEF = 5;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_MOD = 3'b011,
        OP_AND = 3'b100,
        OP_CAT = 3'b101,
        OP_SRL = 3'b110,
        OP_SLL = 3'b111
    } opcode_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/ex_stage_if.sv
// Decode -> execute -> writeback handshake bundle.
// slave: the execute stage; master: the surrounding pipeline.
interface ex_stage_if #(
    parameter int N  = 32,
    parameter int RW = 5
) ();

    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_opcode;
    logic [N-1:0]  in_a;
    logic [N-1:0]  in_b;
    logic [RW-1:0] in_rd;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_result;
    logic          out_carry;
    logic [RW-1:0] out_rd;

    modport slave (
        input  in_valid, in_opcode, in_a, in_b, in_rd, out_ready,
        output in_ready, out_valid, out_result, out_carry, out_rd
    );

    modport master (
        output in_valid, in_opcode, in_a, in_b, in_rd, out_ready,
        input  in_ready, out_valid, out_result, out_carry, out_rd
    );

endinterface

// File: rtl/mod_iter.sv
// Restoring shift-subtract remainder unit, one quotient bit per cycle.
// done is combinational on the final iteration; remainder is valid with it.
module mod_iter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         done,
    output logic [N-1:0] remainder
);

    localparam int CW = $clog2(N);

    logic [N-1:0]  q_q;
    logic [N-1:0]  d_q;
    logic [N-1:0]  r_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic [N:0]    shl;
    logic [N:0]    diff;
    logic [N-1:0]  r_next;

    // One restoring step: shift in next dividend bit, subtract if it fits.
    always_comb begin
        shl    = {r_q, q_q[N-1]};
        diff   = shl - {1'b0, d_q};
        r_next = (shl >= {1'b0, d_q}) ? diff[N-1:0] : shl[N-1:0];
    end

    assign done      = busy_q && (cnt_q == CW'(N - 1));
    assign remainder = r_next;

    // Iteration state; a zero divisor naturally leaves the dividend.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q    <= '0;
            d_q    <= '0;
            r_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            q_q    <= dividend;
            d_q    <= divisor;
            r_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            r_q   <= r_next;
            q_q   <= q_q << 1;
            cnt_q <= cnt_q + 1'b1;
            if (done) begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
            end
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU with a registered valid/ready output.
// EX_STAGE_ITER_MOD_EN: mod runs on the iterative mod_iter unit (BUSY).
module ex_stage
    import ex_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int RW = RW_DEF
) (
    input logic      clk,
    input logic      rst,
    ex_stage_if.slave bus
);

    state_t       state_q;
    state_t       state_d;
    opcode_t      op;
    logic         accept;
    logic         load_alu;
    logic [N:0]   sum;
    logic [N-1:0] res_d;
    logic         carry_d;
    logic         mod_done;
    logic [N-1:0] mod_rem;

    assign op          = opcode_t'(bus.in_opcode);
    assign bus.in_ready = (state_q == IDLE) &&
                          (!bus.out_valid || bus.out_ready);
    assign accept      = bus.in_valid && bus.in_ready;
    assign sum         = {1'b0, bus.in_a} + {1'b0, bus.in_b};

`ifdef EX_STAGE_ITER_MOD_EN
    logic mod_start;

    mod_iter #(.N(N)) u_mod (
        .clk       (clk),
        .rst       (rst),
        .start     (mod_start),
        .dividend  (bus.in_a),
        .divisor   (bus.in_b),
        .done      (mod_done),
        .remainder (mod_rem)
    );
`else
    assign mod_done = 1'b0;
    assign mod_rem  = '0;
`endif

    // Single-cycle result and carry for the presented opcode.
    always_comb begin
        res_d   = '0;
        carry_d = 1'b0;
        unique case (op)
            OP_ADD: {carry_d, res_d} = sum;
            OP_SUB: res_d = bus.in_a - bus.in_b;
            OP_MUL: res_d = bus.in_a * bus.in_b;
            OP_AND: res_d = bus.in_a & bus.in_b;
            OP_CAT: res_d = {{(N - 16){1'b0}}, bus.in_a[7:0], bus.in_b[7:0]};
            OP_SRL: res_d = (bus.in_b >= N'(N)) ? '0 : bus.in_a >> bus.in_b;
            OP_SLL: res_d = (bus.in_b >= N'(N)) ? '0 : bus.in_a << bus.in_b;
`ifdef EX_STAGE_ITER_MOD_EN
            OP_MOD: res_d = '0;
`else
            OP_MOD: res_d = (bus.in_b == '0) ? bus.in_a : bus.in_a % bus.in_b;
`endif
            default: res_d = '0;
        endcase
    end

    // Next state and accept routing (ALU load vs. iterative start).
    always_comb begin
        state_d  = state_q;
        load_alu = 1'b0;
`ifdef EX_STAGE_ITER_MOD_EN
        mod_start = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef EX_STAGE_ITER_MOD_EN
                    if (op == OP_MOD) begin
                        mod_start = 1'b1;
                        state_d   = BUSY;
                    end else begin
                        load_alu = 1'b1;
                    end
`else
                    load_alu = 1'b1;
`endif
                end
            end
            BUSY: begin
                if (mod_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register and held output; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            bus.out_valid  <= 1'b0;
            bus.out_result <= '0;
            bus.out_carry  <= 1'b0;
            bus.out_rd     <= '0;
        end else begin
            state_q <= state_d;
            if (load_alu) begin
                bus.out_valid  <= 1'b1;
                bus.out_result <= res_d;
                bus.out_carry  <= carry_d;
                bus.out_rd     <= bus.in_rd;
            end else if (mod_done) begin
                bus.out_valid  <= 1'b1;
                bus.out_result <= mod_rem;
                bus.out_carry  <= 1'b0;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
`ifdef EX_STAGE_ITER_MOD_EN
            if (mod_start) bus.out_rd <= bus.in_rd;
`endif
        end
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameter: N, 32, operand/result width in bits.
REQ-002 Parameter: RW, 5, destination register index width.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: in_valid  input  1  upstream (decode) presents an operation.
REQ-006 Port: in_ready  output  1  stage accepts the operation this cycle.
REQ-007 Port: in_opcode  input  3  000 add, 001 sub, 010 mul, 011 mod, 100 and, 101 concat, 110 srl, 111 sll.
REQ-008 Port: in_a, in_b  input  N  operands.
REQ-009 Port: in_rd  input  RW  destination register index, passed through.
REQ-010 Port: out_valid  output  1  registered result available to writeback.
REQ-011 Port: out_ready  input  1  writeback consumes the result.
REQ-012 Port: out_result  output  N  registered result.
REQ-013 Port: out_carry  output  1  registered carry.
REQ-014 Port: out_rd  output  RW  destination index of the held result.

Function
REQ-015 Accept occurs on a cycle with in_valid && in_ready; operands, opcode, and rd are captured at that edge.
REQ-016 in_ready = (state == IDLE) && (!out_valid || out_ready); combinational, no dependence on in_valid.
REQ-017 States: IDLE, BUSY; output holding is tracked by out_valid, not by a separate state.
REQ-018 Single-cycle opcodes (all except iterative mod): out_valid rises the cycle after accept (latency 1), result and rd loaded at the accept edge.
REQ-019 add: {out_carry, out_result} = in_a + in_b (N+1-bit sum); all other opcodes: out_carry = 0.
REQ-020 sub, mul, and: low N bits of in_a-in_b, in_a*in_b, in_a&in_b; wrap-around is discarded silently.
REQ-021 concat: result = {zeros, in_a[7:0], in_b[7:0]}, zero-extended to N.
REQ-022 srl/sll: logical shift of in_a by in_b; any in_b >= N yields 0.
REQ-023 mod: result = in_a % in_b (unsigned); in_b == 0 yields in_a.
REQ-024 out_valid clears on out_ready when no new accept occurs; simultaneous out_ready and accept loads the new result with out_valid held at 1 (full throughput, one op per cycle).
REQ-025 out_result, out_carry, and out_rd are stable while out_valid && !out_ready.
REQ-026 In BUSY, in_ready = 0; out_valid of any previously completed result still drains normally.
REQ-027 BUSY -> IDLE after the iteration counter reaches N-1; the result is loaded and out_valid is set at that edge.

Reset
REQ-028 On rst: state = IDLE, out_valid = 0, out_result = 0, out_carry = 0, out_rd = 0, iteration counter = 0.
REQ-029 rst asserted in BUSY aborts the mod; no result is produced for it.
REQ-030 rst has priority over accept and over out_ready in the same cycle.

Configuration
REQ-031 Macro EX_STAGE_ITER_MOD_EN: when defined, mod enters BUSY and uses a restoring shift-subtract unit, one quotient bit per cycle, N cycles; out_valid is asserted N+1 cycles after the accept edge.
REQ-032 Without EX_STAGE_ITER_MOD_EN: mod is single-cycle per REQ-018 and BUSY is unreachable; results are identical in both builds, including mod-by-zero.

Structure
REQ-033 The shared package ex_pkg holds the opcode enum (the eight codes above), the state enum, and the default N/RW constants.
REQ-034 The sub-module mod_iter (start, dividend, divisor, done, remainder) holds the iterative remainder datapath; it is instantiated only under EX_STAGE_ITER_MOD_EN.

Verification
REQ-035 add 0xFFFFFFFF + 0x00000001, out_ready = 1 -> next cycle out_valid = 1, result 0x00000000, carry 1.
REQ-036 Back-to-back: sub 5-7, then sll 1<<31, then srl 0x80000000>>32, with out_ready held at 1 -> results 0xFFFFFFFE, 0x80000000, 0 on consecutive cycles, in_ready always 1.
REQ-037 Backpressure: concat A=0x12345678, B=0xAABBCCDD, with out_ready = 0 for 3 cycles -> in_ready = 0, result 0x000078DD stable, out_rd unchanged; released when out_ready = 1.
REQ-038 With macro: mod 100 % 7 -> in_ready = 0 for 32 cycles, out_valid on cycle 33, result 2; mod 9 % 0 -> result 9.
REQ-039 With macro: rst asserted at cycle 10 of a mod -> next cycle state IDLE, out_valid = 0; the next accept behaves normally.
REQ-040 Without macro: mod 100 % 7 -> result 2 at latency 1; mul 0x00010000*0x00010000 -> 0.
